// File: rtl/dbg_pkg.sv
// Shared opcodes, FSM states and response-byte defaults for the debug command engine.
package dbg_pkg;

  localparam logic [7:0] OP_RD_RF = 8'h01;
  localparam logic [7:0] OP_RD_DM = 8'h02;
  localparam logic [7:0] OP_RD_IM = 8'h03;
  localparam logic [7:0] OP_WR_DM = 8'h04;
  localparam logic [7:0] OP_WR_IM = 8'h05;
  localparam logic [7:0] OP_STEP  = 8'h06;
  localparam logic [7:0] OP_RD_PC = 8'h07;

  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_SETUP,
    WR_PULSE,
    RD_WAIT,
    SEND,
    STEP
  } state_t;

  function automatic logic op_has_addr(input logic [7:0] op);
    return (op >= OP_RD_RF) && (op <= OP_WR_IM);
  endfunction

  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WR_DM) || (op == OP_WR_IM);
  endfunction

endpackage

// File: rtl/dbg_tx_shifter.sv
// Response serializer: holds up to 4 bytes, presents them MSB first, one per tx handshake.
// tx_data/tx_valid hold while tx_ready is low; load has priority and only occurs while empty.
module dbg_tx_shifter
  import dbg_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [31:0] shreg;
  logic [2:0]  cnt;
  logic        hs;

  assign hs       = tx_valid && tx_ready;
  assign tx_data  = shreg[31:24];
  assign tx_valid = (cnt != 3'd0);
  assign last     = hs && (cnt == 3'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= load_count;
    end else if (hs) begin
      shreg <= {shreg[23:0], 8'h00};
      cnt   <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/dbg_cmd_engine.sv
// Byte-framed debug command engine: decodes rx frames, drives CPU debug accesses, returns ACK/NAK/read data.
// First tx_valid READ_WAIT+1 cycles after the last rx byte for reads, 3 for writes, 2 for step; rx outside framing states is dropped.
module dbg_cmd_engine
  import dbg_pkg::*;
#(
  parameter int         READ_WAIT = 2,
  parameter logic [7:0] ACK_BYTE  = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE  = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        debug,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic        we_dm,
  output logic        we_im,
  output logic        clk_ld,
  input  logic [31:0] dout_rf,
  input  logic [31:0] dout_dm,
  input  logic [31:0] dout_im,
  input  logic [31:0] pc_chk,
  output logic        step,
  output logic        busy
);

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [31:0] addr_q, din_q, rd_bus, ld_data;
  logic [1:0]  byte_cnt;
  logic [3:0]  wait_cnt;
  logic [2:0]  ld_count;
  logic        ld, tx_last, last_byte, wr_phase;

  assign last_byte = rx_valid && (byte_cnt == 2'd3);

  always_comb begin
    rd_bus = pc_chk;
    case (op_q)
      OP_RD_RF: rd_bus = dout_rf;
      OP_RD_DM: rd_bus = dout_dm;
      OP_RD_IM: rd_bus = dout_im;
      default:  rd_bus = pc_chk;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ld       = 1'b0;
    ld_data  = {ACK_BYTE, 24'h0};
    ld_count = 3'd1;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (op_has_addr(rx_data))     state_d = GET_ADDR;
        else if (rx_data == OP_STEP)  state_d = STEP;
        else if (rx_data == OP_RD_PC) state_d = RD_WAIT;
        else begin
          ld      = 1'b1;
          ld_data = {NAK_BYTE, 24'h0};
          state_d = SEND;
        end
      end
      GET_ADDR: if (last_byte) state_d = op_is_write(op_q) ? GET_DATA : RD_WAIT;
      GET_DATA: if (last_byte) state_d = WR_SETUP;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: begin
        ld      = 1'b1;
        state_d = SEND;
      end
      // The selected bus is sampled on the final wait cycle, straight into the serializer.
      RD_WAIT: if (wait_cnt == 4'd0) begin
        ld       = 1'b1;
        ld_data  = rd_bus;
        ld_count = 3'd4;
        state_d  = SEND;
      end
      SEND: if (tx_last) state_d = IDLE;
      STEP: begin
        ld      = 1'b1;
        state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      byte_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: if (rx_valid) begin
          op_q     <= rx_data;
          byte_cnt <= 2'd0;
        end
        GET_ADDR: if (rx_valid) begin
          addr_q   <= {addr_q[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        GET_DATA: if (rx_valid) begin
          din_q    <= {din_q[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
      if (state_q == RD_WAIT) wait_cnt <= wait_cnt - 4'd1;
      else                    wait_cnt <= WAIT_INIT;
    end
  end

  // Strobes decode straight from the state register so reset clears them asynchronously.
  assign wr_phase = (state_q == WR_SETUP) || (state_q == WR_PULSE);
  assign busy     = (state_q != IDLE);
  assign debug    = wr_phase || (state_q == RD_WAIT);
  assign we_dm    = wr_phase && (op_q == OP_WR_DM);
  assign we_im    = wr_phase && (op_q == OP_WR_IM);
  assign clk_ld   = (state_q == WR_PULSE);
  assign step     = (state_q == STEP);
  assign addr     = addr_q;
  assign din      = din_q;

  dbg_tx_shifter u_tx (
    .clk        (clk),
    .rstn       (rstn),
    .load       (ld),
    .load_data  (ld_data),
    .load_count (ld_count),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .last       (tx_last)
  );

endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Scoreboard bench for dbg_cmd_engine: directed frames push expected bytes/latencies, a monitor pops and compares.
module tb_dbg_cmd_engine;

  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] dout_rf = '0, dout_dm = '0, dout_im = '0, pc_chk = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, debug, we_dm, we_im, clk_ld, step, busy;
  logic [31:0] addr, din;

  dbg_cmd_engine #(.READ_WAIT(RW), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .debug(debug), .addr(addr), .din(din), .we_dm(we_dm), .we_im(we_im),
    .clk_ld(clk_ld), .dout_rf(dout_rf), .dout_dm(dout_dm), .dout_im(dout_im),
    .pc_chk(pc_chk), .step(step), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0, rx_cyc = 0, lat_exp = 0;
  int ld_cnt = 0, step_cnt = 0, dbg_cnt = 0;
  int rdy_mode = 0;  // 0 hold low, 1 always high, 2 toggle
  logic [7:0]  exp_q[$];
  int          lat_q[$];
  logic [31:0] exp_addr = '0, exp_din = '0;
  logic        exp_we_dm = 1'b0;
  logic        prev_stall = 1'b0, prev_tx_valid = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #2;
    tx_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? ~tx_ready : 1'b0;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_valid) rx_cyc = cyc;
      if (tx_valid && !prev_tx_valid && lat_q.size() > 0) begin
        lat_exp = lat_q.pop_front();
        check("latency", 32'(cyc - rx_cyc), 32'(lat_exp));
      end
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1'b1);
        check("stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected: got %h required no byte", tx_data);
        end else check("tx_byte", tx_data, exp_q.pop_front());
      end
      if (clk_ld) begin
        ld_cnt++;
        check("wr_addr", addr, exp_addr);
        check("wr_din", din, exp_din);
        check("wr_we_dm", we_dm, exp_we_dm);
        check("wr_we_im", we_im, !exp_we_dm);
        check("wr_debug", debug, 1'b1);
      end
      if (step) step_cnt++;
      if (debug) dbg_cnt++;
      prev_stall    = tx_valid && !tx_ready;
      prev_data     = tx_data;
      prev_tx_valid = tx_valid;
    end else begin
      prev_stall    = 1'b0;
      prev_tx_valid = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_resp(input logic [31:0] w, input int nbytes, input int lat);
    for (int i = 3; i >= 4 - nbytes; i--) exp_q.push_back(w[i*8 +: 8]);
    lat_q.push_back(lat);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && lat_q.size() == 0 && !busy) break;
    end
    if (i == 300) begin
      n_total++;
      $display("FAIL wait_idle: got %0d bytes outstanding required 0 within 300 cycles", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_debug"}, debug, 1'b0);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_din"}, din, 32'h0);
    check({tag, "_we_dm"}, we_dm, 1'b0);
    check({tag, "_we_im"}, we_im, 1'b0);
    check({tag, "_clk_ld"}, clk_ld, 1'b0);
    check({tag, "_step"}, step, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ld, base_step, base_dbg, k;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1; rdy_mode = 1;

    // write DM: 04 00000010 DEADBEEF
    exp_addr = 32'h10; exp_din = 32'hDEADBEEF; exp_we_dm = 1'b1;
    base_ld = ld_cnt;
    push_resp(32'h06000000, 1, 3);
    send_byte(8'h04); send_word(32'h10); send_word(32'hDEADBEEF);
    wait_idle();
    check("wr_dm_clk_ld_cycles", 32'(ld_cnt - base_ld), 32'd1);

    // read DM
    dout_dm = 32'hDEADBEEF;
    push_resp(32'hDEADBEEF, 4, RW + 1);
    send_byte(8'h02); send_word(32'h10);
    wait_idle();

    // read RF
    dout_rf = 32'h01020304;
    push_resp(32'h01020304, 4, RW + 1);
    send_byte(8'h01); send_word(32'h4);
    wait_idle();

    // read PC with tx_ready toggling
    pc_chk = 32'h00003004;
    rdy_mode = 2;
    push_resp(32'h00003004, 4, RW + 1);
    send_byte(8'h07);
    wait_idle();
    @(posedge clk);
    #1 rdy_mode = 1;

    // step
    base_step = step_cnt;
    push_resp(32'h06000000, 1, 2);
    send_byte(8'h06);
    wait_idle();
    check("step_cycles", 32'(step_cnt - base_step), 32'd1);

    // unknown opcode
    base_ld = ld_cnt; base_step = step_cnt; base_dbg = dbg_cnt;
    push_resp(32'h15000000, 1, 1);
    send_byte(8'hAA);
    wait_idle();
    check("nak_debug_cycles", 32'(dbg_cnt - base_dbg), 32'd0);
    check("nak_clk_ld_cycles", 32'(ld_cnt - base_ld), 32'd0);
    check("nak_step_cycles", 32'(step_cnt - base_step), 32'd0);

    // reset mid-frame, then a full write-IM frame
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    @(posedge clk);
    #3 rstn = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk);
    #1 rstn = 1'b1;
    exp_addr = 32'h20; exp_din = 32'h12345678; exp_we_dm = 1'b0;
    base_ld = ld_cnt;
    push_resp(32'h06000000, 1, 3);
    send_byte(8'h05); send_word(32'h20); send_word(32'h12345678);
    wait_idle();
    check("wr_im_clk_ld_cycles", 32'(ld_cnt - base_ld), 32'd1);

    // rx injected during SEND, including on the final handshake
    rdy_mode = 0;
    dout_dm = 32'h0BADF00D;
    base_step = step_cnt;
    push_resp(32'h0BADF00D, 4, RW + 1);
    send_byte(8'h02); send_word(32'h10);
    for (k = 0; k < 50 && !tx_valid; k++) @(negedge clk);
    check("inject_tx_valid", tx_valid, 1'b1);
    send_byte(8'h07); send_byte(8'h06);
    @(negedge clk);
    check("inject_busy_stalled", busy, 1'b1);
    @(posedge clk);
    #1 rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1 rx_data = 8'h06; rx_valid = 1'b1;
    @(negedge clk);
    check("inject_busy_final", busy, 1'b1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    check("inject_busy_after", busy, 1'b0);
    wait_idle();
    repeat (6) @(negedge clk);
    check("inject_no_new_frame", busy, 1'b0);
    check("inject_step_cycles", 32'(step_cnt - base_step), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_engine.md
DBG_CMD_ENGINE -- requirements
Module: dbg_cmd_engine

Interface
REQ-001 Parameter READ_WAIT, default 2: cycles between driving addr and sampling read data (legal range 1..15).
REQ-002 Parameter ACK_BYTE, default 8'h06: response byte for a completed write or step.
REQ-003 Parameter NAK_BYTE, default 8'h15: response byte for an unknown opcode.
REQ-004 Reset is asynchronous and active-low; the design has one clock.
REQ-005 clk  in  1  system clock; all logic rises on posedge clk.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 rx_data  in  8  command byte from the serial receiver.
REQ-008 rx_valid  in  1  one-cycle strobe: rx_data holds a valid byte.
REQ-009 tx_data  out  8  response byte to the serial transmitter.
REQ-010 tx_valid  out  1  tx_data valid; held until the tx_ready handshake completes.
REQ-011 tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
REQ-012 debug  out  1  CPU debug-port select; high while a debug access is in progress.
REQ-013 addr  out  32  debug address to the CPU.
REQ-014 din  out  32  debug write data to the CPU.
REQ-015 we_dm / we_im  out  1 each  data-memory and instruction-memory write enables.
REQ-016 clk_ld  out  1  one-cycle load strobe that commits a debug write.
REQ-017 dout_rf / dout_dm / dout_im / pc_chk  in  32 each  CPU read-back buses.
REQ-018 step  out  1  one-cycle request to advance the CPU clock by one period.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 Opcodes: 01 read RF, 02 read DM, 03 read IM, 04 write DM, 05 write IM, 06 step, 07 read PC.
REQ-021 Frame format: opcode byte; opcodes 01-05 are followed by 4 address bytes, MSB first; opcodes 04-05 are then followed by 4 data bytes, MSB first.
REQ-022 FSM states: IDLE, GET_ADDR, GET_DATA, WR_SETUP, WR_PULSE, RD_WAIT, SEND, STEP.
REQ-023 In IDLE, rx_valid with opcode 01-05 goes to GET_ADDR; 06 goes to STEP; 07 goes to RD_WAIT; any other opcode loads NAK_BYTE and goes to SEND.
REQ-024 GET_ADDR and GET_DATA shift bytes in with a 2-bit counter; the 4th byte advances the FSM to RD_WAIT (reads) or GET_DATA (writes), then from GET_DATA to WR_SETUP (writes).
REQ-025 WR_SETUP: debug=1, addr and din stable, and the selected we_* high for one cycle; the FSM then enters WR_PULSE.
REQ-026 WR_PULSE: clk_ld=1 for exactly one cycle, with addr, din and we_* unchanged; the FSM then loads ACK_BYTE and goes to SEND.
REQ-027 RD_WAIT: debug=1 for READ_WAIT cycles; on the last cycle the selected bus (pc_chk for opcode 07) is captured into a 32-bit response register, and the FSM goes to SEND with a count of 4.
REQ-028 SEND: tx_valid=1; each handshake shifts out the next byte, MSB first; after the last byte the FSM returns to IDLE.
REQ-029 The response length is 4 bytes for reads and 1 byte for ACK or NAK.
REQ-030 STEP: step=1 for one cycle; the FSM then loads ACK_BYTE and goes to SEND.
REQ-031 rx_valid outside IDLE, GET_ADDR and GET_DATA is dropped without effect.
REQ-032 tx_data and tx_valid stay stable while tx_ready is low.
REQ-033 An rx_valid arriving in the same cycle as the final SEND handshake is dropped; a new frame starts only from IDLE.
REQ-034 Command latency from the last rx byte: first tx_valid after READ_WAIT+1 cycles for reads, 3 cycles for writes, 2 cycles for a step.
REQ-035 we_dm, we_im, clk_ld and step are never high outside the states defined above.

Reset
REQ-036 While rstn is low, the state is IDLE and every output is 0.
REQ-037 A reset asserted mid-frame discards the partial frame; clk_ld, we_* and step go low immediately and asynchronously.

Structure
REQ-038 A shared package dbg_pkg SHALL hold the opcode constants, the state enumeration, and the ACK and NAK defaults.
REQ-039 The response serializer SHALL be one sub-module, dbg_tx_shifter, containing the 32-bit register, the byte count and the tx handshake.

Verification
REQ-040 Send 04 00000010 DEADBEEF -> we_dm=1, addr=0x10 and din=0xDEADBEEF; clk_ld high for exactly one cycle; tx byte 06.
REQ-041 Send 02 00000010 with dout_dm=0xDEADBEEF -> tx bytes DE AD BE EF, first tx_valid READ_WAIT+1 cycles after the last rx byte.
REQ-042 Send 07 with pc_chk=0x00003004 and tx_ready toggling every other cycle -> tx bytes 00 00 30 04, with tx_data stable during stalls.
REQ-043 Send 06 -> step high for exactly one cycle, then tx byte 06; send 0xAA -> tx byte 15 and no debug activity.
REQ-044 Deassert rstn after 2 of 4 address bytes -> all outputs 0; a following complete 05 frame executes correctly.
REQ-045 Inject rx bytes during SEND -> bytes ignored; response unaltered; busy drops only after the final handshake.
